sm_run_ctrl: RTL and testbench

Execution controller for the single-cycle schoolRISCV core. It drives the core's clock-enable and sequences execution from a halted state. Supported modes are free-run, single-step, run-N-instructions, and halt-on-PC-breakpoint. It sits between the debug/command source and `sm_top`'s `clkEnable` input, and observes the core's current `pc`.

---
 rtl/sm_run_ctrl_if.sv | 25 ++
 rtl/sm_run_ctrl.sv | 130 +++++++++++++
 tb/tb_sm_run_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sm_run_ctrl_if.sv
// Command handshake between the debug/command source and the run controller.
interface sm_run_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic             cmdValid;
    logic             cmdReady;
    logic [1:0]       cmdOp;
    logic [CNT_W-1:0] cmdArg;

    // Command source side
    modport master (
        output cmdValid,
        output cmdOp,
        output cmdArg,
        input  cmdReady
    );

    // Run controller side
    modport slave (
        input  cmdValid,
        input  cmdOp,
        input  cmdArg,
        output cmdReady
    );
endinterface

// File: rtl/sm_run_ctrl.sv
// Execution controller for the single-cycle schoolRISCV core: gates the core
// clock-enable for free-run, single-step, run-N and PC-breakpoint halting.
module sm_run_ctrl #(
    parameter int CNT_W = 16,
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    sm_run_ctrl_if.slave     cmd,
    input  logic             bpEnable,
    input  logic [PC_W-1:0]  bpAddr,
    input  logic [PC_W-1:0]  pc,
    output logic             cpuEnable,
    output logic             halted,
    output logic [1:0]       haltCause,
    output logic [CNT_W-1:0] instrCount
);
    localparam logic [1:0] ST_HALT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_COUNT = 2'd2;

    localparam logic [1:0] OP_HALT  = 2'd0;
    localparam logic [1:0] OP_RUN   = 2'd1;
    localparam logic [1:0] OP_STEP  = 2'd2;
    localparam logic [1:0] OP_RUN_N = 2'd3;

    localparam logic [1:0] CAUSE_RESET = 2'd0;
    localparam logic [1:0] CAUSE_CMD   = 2'd1;
    localparam logic [1:0] CAUSE_COUNT = 2'd2;
    localparam logic [1:0] CAUSE_BP    = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [1:0]       stateReg, stateNext;
    logic [CNT_W-1:0] remainingReg, remainingNext;
    logic             firstReg, firstNext;
    logic [1:0]       causeReg, causeNext;
    logic [CNT_W-1:0] instrCountReg;
    logic             bpHit;
    logic             cmdAccept;

    assign halted         = (stateReg == ST_HALT);
    // The first cycle after leaving HALT must execute even if it sits on the breakpoint
    assign bpHit          = bpEnable && (pc == bpAddr) && !firstReg && !halted;
    assign cpuEnable      = !halted && !bpHit;
    // Only HALT may interrupt a running controller; everything else waits
    assign cmd.cmdReady   = halted || (cmd.cmdOp == OP_HALT);
    assign cmdAccept      = cmd.cmdValid && cmd.cmdReady;
    assign haltCause      = causeReg;
    assign instrCount     = instrCountReg;

    // Next-state decode: command dispatch from HALT, stop conditions while running
    always_comb begin
        stateNext     = stateReg;
        remainingNext = remainingReg;
        firstNext     = firstReg;
        causeNext     = causeReg;
        case (stateReg)
            ST_HALT: begin
                if (cmdAccept) begin
                    case (cmd.cmdOp)
                        OP_RUN: begin
                            stateNext = ST_RUN;
                            firstNext = 1'b1;
                        end
                        OP_STEP: begin
                            stateNext     = ST_COUNT;
                            remainingNext = CNT_ONE;
                            firstNext     = 1'b1;
                        end
                        OP_RUN_N: begin
                            if (cmd.cmdArg != CNT_ZERO) begin
                                stateNext     = ST_COUNT;
                                remainingNext = cmd.cmdArg;
                                firstNext     = 1'b1;
                            end else begin
                                causeNext = CAUSE_COUNT;
                            end
                        end
                        default: causeNext = CAUSE_CMD;
                    endcase
                end
            end
            ST_RUN, ST_COUNT: begin
                firstNext = 1'b0;
                if (bpHit) begin
                    stateNext = ST_HALT;
                    causeNext = CAUSE_BP;
                end else if (cmdAccept && (cmd.cmdOp == OP_HALT)) begin
                    stateNext = ST_HALT;
                    causeNext = CAUSE_CMD;
                end else if (stateReg == ST_COUNT) begin
                    // No breakpoint here means cpuEnable is high this cycle
                    remainingNext = remainingReg - CNT_ONE;
                    if (remainingReg == CNT_ONE) begin
                        stateNext = ST_HALT;
                        causeNext = CAUSE_COUNT;
                    end
                end
            end
            default: stateNext = ST_HALT;
        endcase
    end

    // Controller state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg     <= ST_HALT;
            remainingReg <= CNT_ZERO;
            firstReg     <= 1'b0;
            causeReg     <= CAUSE_RESET;
        end else begin
            stateReg     <= stateNext;
            remainingReg <= remainingNext;
            firstReg     <= firstNext;
            causeReg     <= causeNext;
        end
    end

    // Retired-instruction counter, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instrCountReg <= CNT_ZERO;
        end else if (cpuEnable && (instrCountReg != CNT_MAX)) begin
            instrCountReg <= instrCountReg + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_sm_run_ctrl.sv
// Randomized transaction-level bench for sm_run_ctrl with an outcome-based model.
module tb_sm_run_ctrl;
    localparam int CNT_W  = 8;
    localparam int PC_W   = 16;
    localparam int INF    = 1 << 30;
    localparam int BUDGET = 700;
    localparam int SAT    = 255;

    localparam logic [1:0] OP_HALT  = 2'd0;
    localparam logic [1:0] OP_RUN   = 2'd1;
    localparam logic [1:0] OP_STEP  = 2'd2;
    localparam logic [1:0] OP_RUN_N = 2'd3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             bpEnable = 1'b0;
    logic [PC_W-1:0]  bpAddr = '0;
    logic [PC_W-1:0]  pc = '0;
    logic             cpuEnable;
    logic             halted;
    logic [1:0]       haltCause;
    logic [CNT_W-1:0] instrCount;

    int testsRun = 0;
    int testsFailed = 0;
    int modelTotal = 0;
    int txnNum = 0;

    sm_run_ctrl_if #(.CNT_W(CNT_W)) cmdIf ();

    sm_run_ctrl #(.CNT_W(CNT_W), .PC_W(PC_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmdIf),
        .bpEnable   (bpEnable),
        .bpAddr     (bpAddr),
        .pc         (pc),
        .cpuEnable  (cpuEnable),
        .halted     (halted),
        .haltCause  (haltCause),
        .instrCount (instrCount)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic finishRun();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    endtask

    // Issue one command from HALT and follow it until the controller halts again.
    // Called at #1 after a rising edge; returns at #1 after a rising edge.
    task automatic runTxn(input logic [1:0] op, input int arg, input logic bpOn,
                          input int bpA, input int haltAt, input bit probe);
        int n, i, k, cause, diff, c, lead, ens;
        bit gap, done, en;
        // Outcome model: instruction index of breakpoint hit (i), of HALT (haltAt), count limit (n)
        diff = (bpA - int'(pc)) & 32'hFFFF;
        if (!bpOn || (diff % 4) != 0) i = INF;
        else if (diff == 0)            i = 65536 / 4;
        else                           i = diff / 4;
        if (op == OP_HALT) begin
            k = 0; cause = 1;
        end else if (op == OP_RUN_N && arg == 0) begin
            k = 0; cause = 2;
        end else begin
            n = (op == OP_RUN) ? INF : (op == OP_STEP) ? 1 : arg;
            if (i <= haltAt && i <= n - 1) begin
                k = i; cause = 3;
            end else if (haltAt <= n - 1) begin
                k = haltAt + 1; cause = 1;
            end else begin
                k = n; cause = 2;
            end
        end

        bpEnable       = bpOn;
        bpAddr         = PC_W'(bpA);
        cmdIf.cmdValid = 1'b1;
        cmdIf.cmdOp    = op;
        cmdIf.cmdArg   = CNT_W'(arg);
        @(posedge clk); #1;
        cmdIf.cmdValid = 1'b0;

        c = 0; lead = 0; ens = 0; gap = 0; done = 0;
        while (!done) begin
            if (halted) begin
                done = 1;
            end else if (c >= BUDGET) begin
                checkVal("timeout", 32'(halted), 32'd1);
                finishRun();
            end else begin
                if (c == haltAt) begin
                    cmdIf.cmdValid = 1'b1; cmdIf.cmdOp = OP_HALT;
                end else if (probe) begin
                    cmdIf.cmdValid = 1'b1; cmdIf.cmdOp = OP_RUN;
                end else begin
                    cmdIf.cmdValid = 1'b0;
                end
                @(negedge clk);
                if (c == haltAt)  checkVal("haltReady", 32'(cmdIf.cmdReady), 32'd1);
                else if (probe)   checkVal("stallReady", 32'(cmdIf.cmdReady), 32'd0);
                en = cpuEnable;
                if (en) begin
                    ens++;
                    if (!gap) lead++;
                end else begin
                    gap = 1;
                end
                @(posedge clk); #1;
                cmdIf.cmdValid = 1'b0;
                if (en) pc = pc + PC_W'(4);
                c++;
            end
        end

        modelTotal = (modelTotal + k > SAT) ? SAT : modelTotal + k;
        checkVal("leadEnables", 32'(lead), 32'(k));
        checkVal("totalEnables", 32'(ens), 32'(k));
        checkVal("runCycles", 32'(c), 32'(k + ((cause == 3) ? 1 : 0)));
        checkVal("haltCause", 32'(haltCause), 32'(cause));
        checkVal("instrCount", 32'(instrCount), 32'(modelTotal));
        txnNum++;
        $display("[TB] txn %0d op=%0d arg=%0d bp=%0d@%0h haltAt=%0d -> exec=%0d cause=%0d count=%0d",
                 txnNum, op, arg, bpOn, bpA & 32'hFFFF, (haltAt == INF) ? -1 : haltAt,
                 ens, haltCause, instrCount);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] op;
        int arg, bpA, haltAt;
        logic bpOn;
        bit probe;

        cmdIf.cmdValid = 1'b0;
        cmdIf.cmdOp    = OP_HALT;
        cmdIf.cmdArg   = '0;

        // Reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkVal("rstHalted", 32'(halted), 32'd1);
        checkVal("rstCpuEn", 32'(cpuEnable), 32'd0);
        checkVal("rstCause", 32'(haltCause), 32'd0);
        checkVal("rstCount", 32'(instrCount), 32'd0);
        checkVal("rstReady", 32'(cmdIf.cmdReady), 32'd1);
        @(posedge clk); #1;

        // Directed scenarios
        pc = '0;
        repeat (3) runTxn(OP_STEP, 0, 1'b0, 0, INF, 1'b0);
        runTxn(OP_RUN_N, 5, 1'b0, 0, INF, 1'b0);
        runTxn(OP_RUN_N, 0, 1'b0, 0, INF, 1'b0);
        pc = '0;
        runTxn(OP_RUN, 0, 1'b1, 32'h0C, 50, 1'b0);
        checkVal("bpPc", 32'(pc), 32'h0C);
        runTxn(OP_STEP, 0, 1'b1, 32'h0C, INF, 1'b0);
        runTxn(OP_RUN, 0, 1'b0, 0, 7, 1'b1);
        runTxn(OP_HALT, 0, 1'b0, 0, INF, 1'b0);
        pc = '0;
        runTxn(OP_RUN, 0, 1'b1, 32'h10, 4, 1'b0);
        pc = '0;
        runTxn(OP_RUN_N, 4, 1'b1, 32'h0C, INF, 1'b0);
        runTxn(OP_RUN_N, 255, 1'b0, 0, INF, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 50; t++) begin
            op  = 2'($urandom_range(0, 3));
            arg = ($urandom_range(0, 9) == 0) ? int'($urandom_range(100, 255)) : int'($urandom_range(0, 12));
            if ($urandom_range(0, 3) == 0) pc = PC_W'($urandom_range(0, 16383) * 4);
            bpOn = 1'($urandom_range(0, 1));
            bpA  = int'(pc) + 4 * int'($urandom_range(0, 15)) + (($urandom_range(0, 7) == 0) ? 1 : 0);
            if (op == OP_RUN)              haltAt = int'($urandom_range(0, 40));
            else if ($urandom_range(0, 2) == 0) haltAt = int'($urandom_range(0, arg));
            else                           haltAt = INF;
            probe = 1'($urandom_range(0, 1));
            runTxn(op, arg, bpOn, bpA, haltAt, probe);
        end

        // Reset in the middle of a RUN_N 10
        bpEnable       = 1'b0;
        cmdIf.cmdValid = 1'b1;
        cmdIf.cmdOp    = OP_RUN_N;
        cmdIf.cmdArg   = CNT_W'(10);
        @(posedge clk); #1;
        cmdIf.cmdValid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        checkVal("preRstEn", 32'(cpuEnable), 32'd1);
        rst_n = 1'b0;
        #1;
        checkVal("asyncEnDrop", 32'(cpuEnable), 32'd0);
        checkVal("asyncHalted", 32'(halted), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkVal("postRstHalted", 32'(halted), 32'd1);
        checkVal("postRstCpuEn", 32'(cpuEnable), 32'd0);
        checkVal("postRstCause", 32'(haltCause), 32'd0);
        checkVal("postRstCount", 32'(instrCount), 32'd0);
        checkVal("postRstReady", 32'(cmdIf.cmdReady), 32'd1);
        modelTotal = 0;
        @(posedge clk); #1;
        runTxn(OP_STEP, 0, 1'b0, 0, INF, 1'b0);

        finishRun();
    end
endmodule
